// File: rtl/uart_tx_arb_loop_if.sv
// Handshake bundle between the UART loopback/transmit arbiter and its surroundings:
// rx FIFO read side, monitor send path, character sources and the tx FIFO write port.
interface uart_tx_arb_loop_if #(
  parameter int DW   = 8,
  parameter int NSRC = 2,
  parameter int CNTW = 8
);
  logic [DW-1:0]      rx_rdata;
  logic               rx_fifo_dvalid;
  logic               rx_rden;
  logic               rx_disable_echoback;
  logic [DW-1:0]      rout;
  logic               rout_en;
  logic               send_en;
  logic [DW-1:0]      send_char;
  logic               send_ack;
  logic [NSRC-1:0]    src_we;
  logic [NSRC*DW-1:0] src_char;
  logic [NSRC-1:0]    src_ack;
  logic [DW-1:0]      tx_wdata;
  logic               tx_wten;
  logic               tx_fifo_full;
  logic [CNTW-1:0]    echo_drop_cnt;
  logic               echo_drop_clr;

  modport master (
    output rx_rdata, rx_fifo_dvalid, rx_disable_echoback, send_en, send_char,
           src_we, src_char, tx_fifo_full, echo_drop_clr,
    input  rx_rden, rout, rout_en, send_ack, src_ack, tx_wdata, tx_wten, echo_drop_cnt
  );

  modport slave (
    input  rx_rdata, rx_fifo_dvalid, rx_disable_echoback, send_en, send_char,
           src_we, src_char, tx_fifo_full, echo_drop_clr,
    output rx_rden, rout, rout_en, send_ack, src_ack, tx_wdata, tx_wten, echo_drop_cnt
  );
endinterface

// File: rtl/uart_tx_arb_loop.sv
// UART loopback/transmit arbiter: buffers rx echoes and merges monitor, request sources
// and echo stream into a single tx FIFO write port (fixed or round-robin priority).
module uart_tx_arb_loop #(
  parameter int DW         = 8,
  parameter int NSRC       = 2,
  parameter int ECHO_DEPTH = 4,
  parameter int RR         = 1,
  parameter int CNTW       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_arb_loop_if.slave bus
);
  localparam int AW    = $clog2(ECHO_DEPTH);
  localparam int NCAND = NSRC + 1;
  localparam int PW    = $clog2(NCAND);

  logic [DW-1:0]   echo_mem_q [ECHO_DEPTH];
  logic [AW:0]     echo_wr_q, echo_wr_d;
  logic [AW:0]     echo_rd_q, echo_rd_d;
  logic [CNTW-1:0] drop_cnt_q, drop_cnt_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DW-1:0]   rout_q, rout_d;
  logic            rout_en_q, rout_en_d;

  logic            echo_empty, echo_full;
  logic            echo_push, echo_push_ok, echo_drop;
  logic [NCAND-1:0] cand_req;
  logic [DW-1:0]   cand_char [NCAND];
  logic            win_valid;
  logic [PW-1:0]   win_idx;
  logic [PW:0]     rr_idx;
  logic            gnt_send, gnt_echo;
  logic [NSRC-1:0] gnt_src;
  logic            tx_wten_c;
  logic [DW-1:0]   tx_wdata_c;

  // Extra wrap bit on the pointers distinguishes full from empty.
  assign echo_empty = (echo_wr_q == echo_rd_q);
  assign echo_full  = (echo_wr_q[AW] != echo_rd_q[AW]) &&
                      (echo_wr_q[AW-1:0] == echo_rd_q[AW-1:0]);

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_cand
      assign cand_req[gi]  = bus.src_we[gi];
      assign cand_char[gi] = bus.src_char[gi*DW +: DW];
    end
  endgenerate

  assign cand_req[NSRC]  = ~echo_empty;
  assign cand_char[NSRC] = echo_mem_q[echo_rd_q[AW-1:0]];

  // Winner among sources+echo; iterating from the far end lets the nearest requester win.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    rr_idx    = '0;
    if (RR != 0) begin
      for (int k = NCAND - 1; k >= 0; k--) begin
        rr_idx = {1'b0, rr_ptr_q} + (PW+1)'(k);
        if (rr_idx >= (PW+1)'(NCAND)) begin
          rr_idx = rr_idx - (PW+1)'(NCAND);
        end
        if (cand_req[rr_idx[PW-1:0]]) begin
          win_valid = 1'b1;
          win_idx   = rr_idx[PW-1:0];
        end
      end
    end else begin
      for (int k = NCAND - 1; k >= 0; k--) begin
        if (cand_req[k]) begin
          win_valid = 1'b1;
          win_idx   = PW'(k);
        end
      end
    end
  end

  always_comb begin
    gnt_send   = 1'b0;
    gnt_echo   = 1'b0;
    gnt_src    = '0;
    tx_wten_c  = 1'b0;
    tx_wdata_c = '0;
    if (rst_n && !bus.tx_fifo_full) begin
      if (bus.send_en) begin
        gnt_send   = 1'b1;
        tx_wten_c  = 1'b1;
        tx_wdata_c = bus.send_char;
      end else if (win_valid) begin
        tx_wten_c  = 1'b1;
        tx_wdata_c = cand_char[win_idx];
        if (win_idx == PW'(NSRC)) begin
          gnt_echo = 1'b1;
        end else begin
          gnt_src[win_idx] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if ((RR != 0) && tx_wten_c && !gnt_send) begin
      rr_ptr_d = (win_idx == PW'(NSRC)) ? '0 : win_idx + PW'(1);
    end
  end

  // A full buffer still accepts a push when the same edge pops an entry.
  always_comb begin
    echo_push    = bus.rx_fifo_dvalid & ~bus.rx_disable_echoback;
    echo_push_ok = echo_push & (~echo_full | gnt_echo);
    echo_drop    = echo_push & echo_full & ~gnt_echo;
    echo_wr_d    = echo_push_ok ? echo_wr_q + (AW+1)'(1) : echo_wr_q;
    echo_rd_d    = gnt_echo ? echo_rd_q + (AW+1)'(1) : echo_rd_q;
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (bus.echo_drop_clr) begin
      drop_cnt_d = '0;
    end else if (echo_drop && (drop_cnt_q != {CNTW{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + CNTW'(1);
    end
  end

  always_comb begin
    rout_d    = bus.rx_fifo_dvalid ? bus.rx_rdata : rout_q;
    rout_en_d = bus.rx_fifo_dvalid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_wr_q  <= '0;
      echo_rd_q  <= '0;
      drop_cnt_q <= '0;
      rr_ptr_q   <= '0;
      rout_q     <= '0;
      rout_en_q  <= 1'b0;
    end else begin
      echo_wr_q  <= echo_wr_d;
      echo_rd_q  <= echo_rd_d;
      drop_cnt_q <= drop_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      rout_q     <= rout_d;
      rout_en_q  <= rout_en_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (echo_push_ok) begin
      echo_mem_q[echo_wr_q[AW-1:0]] <= bus.rx_rdata;
    end
  end

  assign bus.rx_rden       = bus.rx_fifo_dvalid;
  assign bus.rout          = rout_q;
  assign bus.rout_en       = rout_en_q;
  assign bus.send_ack      = gnt_send;
  assign bus.src_ack       = gnt_src;
  assign bus.tx_wten       = tx_wten_c;
  assign bus.tx_wdata      = tx_wdata_c;
  assign bus.echo_drop_cnt = drop_cnt_q;
endmodule
